// File: rtl/player_action_ctrl_pkg.sv
// Shared types and widths for the player action scheduler, sprite mapper and HUD.
package player_action_ctrl_pkg;

    localparam int unsigned HEALTH_W = 7;
    localparam int unsigned DMG_W    = 4;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned GUARD_W  = 6;
    localparam int unsigned RC_W     = 4;
    localparam int unsigned HS_W     = 6;
    localparam int unsigned AGE_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ATTACK   = 3'd1,
        ST_RECOVERY = 3'd2,
        ST_HITSTUN  = 3'd3,
        ST_KO       = 3'd4
    } state_e;

    typedef enum logic {
        ATK_1 = 1'b0,
        ATK_2 = 1'b1
    } atk_id_e;

endpackage

// File: rtl/player_action_ctrl_if.sv
// Command/status handshake between the action scheduler and the attack unit.
interface player_action_ctrl_if;
    logic atk1_start;
    logic atk2_start;
    logic atk_cancel;
    logic attack_busy;

    modport master (
        output atk1_start,
        output atk2_start,
        output atk_cancel,
        input  attack_busy
    );

    modport slave (
        input  atk1_start,
        input  atk2_start,
        input  atk_cancel,
        output attack_busy
    );
endinterface

// File: rtl/player_action_ctrl_input_buffer_1.sv
// Button edge detection, attack-1 priority and a single aging buffered press.
module input_buffer_1
    import player_action_ctrl_pkg::*;
#(
    parameter int unsigned BUFFER_FRAMES = 6
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    scen,
    input  logic    btn_atk1,
    input  logic    btn_atk2,
    input  logic    buf_load,
    input  logic    buf_clear,
    output logic    press_valid_c,
    output atk_id_e press_id_c
);

    logic             prev1_q, prev1_d;
    logic             prev2_q, prev2_d;
    logic             buf_valid_q, buf_valid_d;
    atk_id_e          buf_id_q, buf_id_d;
    logic [AGE_W-1:0] buf_age_q, buf_age_d;

    logic    press1_c, press2_c, fresh_c;
    atk_id_e fresh_id_c;

    // A fresh press beats the buffered one; the buffer only ages on frame strobes.
    always_comb begin
        press1_c   = btn_atk1 & ~prev1_q;
        press2_c   = btn_atk2 & ~prev2_q;
        fresh_c    = press1_c | press2_c;
        fresh_id_c = press1_c ? ATK_1 : ATK_2;

        press_valid_c = fresh_c | buf_valid_q;
        press_id_c    = fresh_c ? fresh_id_c : buf_id_q;

        prev1_d     = prev1_q;
        prev2_d     = prev2_q;
        buf_valid_d = buf_valid_q;
        buf_id_d    = buf_id_q;
        buf_age_d   = buf_age_q;

        if (scen) begin
            prev1_d = btn_atk1;
            prev2_d = btn_atk2;
            if (buf_clear) begin
                buf_valid_d = 1'b0;
                buf_age_d   = '0;
            end else if (buf_load && fresh_c) begin
                buf_valid_d = 1'b1;
                buf_id_d    = fresh_id_c;
                buf_age_d   = '0;
            end else if (buf_valid_q) begin
                buf_age_d   = buf_age_q + AGE_W'(1);
                buf_valid_d = (buf_age_d != AGE_W'(BUFFER_FRAMES));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev1_q     <= 1'b0;
            prev2_q     <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_id_q    <= ATK_1;
            buf_age_q   <= '0;
        end else begin
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
            buf_valid_q <= buf_valid_d;
            buf_id_q    <= buf_id_d;
            buf_age_q   <= buf_age_d;
        end
    end

endmodule

// File: rtl/player_action_ctrl.sv
// Per-player action scheduler: attack starts, recovery lockout, hit/hitstun/KO
// arbitration and health, all advanced on the frame strobe SCEN.
module player_action_ctrl
    import player_action_ctrl_pkg::*;
#(
    parameter int unsigned RECOVERY_FRAMES = 4,
    parameter int unsigned HITSTUN_FRAMES  = 12,
    parameter int unsigned BUFFER_FRAMES   = 6,
    parameter int unsigned ATK_TIMEOUT     = 40,
    parameter int unsigned MAX_HEALTH      = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                SCEN,
    input  logic                btn_atk1,
    input  logic                btn_atk2,
    input  logic                hit_taken,
    input  logic [DMG_W-1:0]    damage_in,
    input  logic                round_restart,
    player_action_ctrl_if.master atk_if,
    output logic                hurt,
    output logic                ko,
    output logic [HEALTH_W-1:0] health,
    output logic [STATE_W-1:0]  state
);

    state_e              state_q, state_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic [GUARD_W-1:0]  guard_q, guard_d;
    logic                seen_q, seen_d;
    logic [RC_W-1:0]     rc_q, rc_d;
    logic [HS_W-1:0]     hs_q, hs_d;
    logic                atk1_start_q, atk1_start_d;
    logic                atk2_start_q, atk2_start_d;
    logic                atk_cancel_q, atk_cancel_d;
    logic                hurt_q, hurt_d;
    logic                ko_q, ko_d;

    logic                buf_load, buf_clear;
    logic                press_valid_c;
    atk_id_e             press_id_c;
    logic [HEALTH_W-1:0] dmg_c;

    input_buffer_1 #(
        .BUFFER_FRAMES (BUFFER_FRAMES)
    ) u_input_buffer (
        .clk           (clk),
        .reset         (reset),
        .scen          (SCEN),
        .btn_atk1      (btn_atk1),
        .btn_atk2      (btn_atk2),
        .buf_load      (buf_load),
        .buf_clear     (buf_clear),
        .press_valid_c (press_valid_c),
        .press_id_c    (press_id_c)
    );

    // Priority per frame: restart, KO hold, incoming hit, then the state's own sequencing.
    always_comb begin
        state_d      = state_q;
        health_d     = health_q;
        guard_d      = guard_q;
        seen_d       = seen_q;
        rc_d         = rc_q;
        hs_d         = hs_q;
        atk1_start_d = atk1_start_q;
        atk2_start_d = atk2_start_q;
        atk_cancel_d = atk_cancel_q;
        hurt_d       = hurt_q;
        ko_d         = ko_q;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        dmg_c        = HEALTH_W'(damage_in);

        if (SCEN) begin
            atk1_start_d = 1'b0;
            atk2_start_d = 1'b0;
            atk_cancel_d = 1'b0;

            if (round_restart) begin
                health_d  = HEALTH_W'(MAX_HEALTH);
                state_d   = ST_IDLE;
                guard_d   = '0;
                seen_d    = 1'b0;
                rc_d      = '0;
                hs_d      = '0;
                buf_clear = 1'b1;
            end else if (state_q == ST_KO) begin
                buf_clear = 1'b1;
            end else if (hit_taken) begin
                health_d  = (health_q > dmg_c) ? (health_q - dmg_c) : '0;
                hs_d      = '0;
                buf_clear = 1'b1;
                state_d   = (health_d == '0) ? ST_KO : ST_HITSTUN;
                if (state_q == ST_ATTACK) begin
                    atk_cancel_d = 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (press_valid_c) begin
                            state_d   = ST_ATTACK;
                            guard_d   = '0;
                            seen_d    = 1'b0;
                            buf_clear = 1'b1;
                            if (press_id_c == ATK_1) begin
                                atk1_start_d = 1'b1;
                            end else begin
                                atk2_start_d = 1'b1;
                            end
                        end
                    end
                    ST_ATTACK: begin
                        buf_load = 1'b1;
                        guard_d  = guard_q + GUARD_W'(1);
                        if (atk_if.attack_busy) begin
                            seen_d = 1'b1;
                        end
                        // seen_q guards against exiting before the unit has acknowledged the start
                        if ((seen_q && !atk_if.attack_busy) ||
                            (guard_d == GUARD_W'(ATK_TIMEOUT))) begin
                            state_d = ST_RECOVERY;
                            rc_d    = '0;
                        end
                    end
                    ST_RECOVERY: begin
                        buf_load = 1'b1;
                        rc_d     = rc_q + RC_W'(1);
                        if (rc_d == RC_W'(RECOVERY_FRAMES)) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_HITSTUN: begin
                        buf_clear = 1'b1;
                        hs_d      = hs_q + HS_W'(1);
                        if (hs_d == HS_W'(HITSTUN_FRAMES)) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            hurt_d = (state_d == ST_HITSTUN);
            ko_d   = (state_d == ST_KO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            health_q     <= HEALTH_W'(MAX_HEALTH);
            guard_q      <= '0;
            seen_q       <= 1'b0;
            rc_q         <= '0;
            hs_q         <= '0;
            atk1_start_q <= 1'b0;
            atk2_start_q <= 1'b0;
            atk_cancel_q <= 1'b0;
            hurt_q       <= 1'b0;
            ko_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            health_q     <= health_d;
            guard_q      <= guard_d;
            seen_q       <= seen_d;
            rc_q         <= rc_d;
            hs_q         <= hs_d;
            atk1_start_q <= atk1_start_d;
            atk2_start_q <= atk2_start_d;
            atk_cancel_q <= atk_cancel_d;
            hurt_q       <= hurt_d;
            ko_q         <= ko_d;
        end
    end

    assign atk_if.atk1_start = atk1_start_q;
    assign atk_if.atk2_start = atk2_start_q;
    assign atk_if.atk_cancel = atk_cancel_q;
    assign hurt              = hurt_q;
    assign ko                = ko_q;
    assign health            = health_q;
    assign state             = state_q;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl; one SCEN strobe every four clocks.
module tb_player_action_ctrl;
    import player_action_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                SCEN;
    logic                btn_atk1;
    logic                btn_atk2;
    logic                hit_taken;
    logic [DMG_W-1:0]    damage_in;
    logic                round_restart;
    logic                hurt;
    logic                ko;
    logic [HEALTH_W-1:0] health;
    logic [STATE_W-1:0]  state;

    int n_cmp = 0;
    int n_err = 0;
    int starts;

    player_action_ctrl_if bus ();

    player_action_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .SCEN          (SCEN),
        .btn_atk1      (btn_atk1),
        .btn_atk2      (btn_atk2),
        .hit_taken     (hit_taken),
        .damage_in     (damage_in),
        .round_restart (round_restart),
        .atk_if        (bus),
        .hurt          (hurt),
        .ko            (ko),
        .health        (health),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: a single SCEN clock followed by three quiet clocks.
    task automatic step();
        @(negedge clk) SCEN = 1'b1;
        @(negedge clk) SCEN = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; SCEN = 1'b0; btn_atk1 = 1'b0; btn_atk2 = 1'b0;
        hit_taken = 1'b0; damage_in = '0; round_restart = 1'b0;
        bus.attack_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_health", 32'(health), 32'd100);
        check_eq("rst_outs", 32'({bus.atk1_start, bus.atk2_start, bus.atk_cancel, hurt, ko}), 32'd0);
        reset = 1'b0;
        step();

        // Basic attack: one-frame start, busy for 7 frames, 4 recovery frames
        btn_atk1 = 1'b1; step();
        check_eq("a1_start", 32'(bus.atk1_start), 32'd1);
        check_eq("a1_state_atk", 32'(state), 32'd1);
        btn_atk1 = 1'b0; step();
        check_eq("a1_start_1frame", 32'(bus.atk1_start), 32'd0);
        bus.attack_busy = 1'b1; steps(7);
        check_eq("a1_busy_state", 32'(state), 32'd1);
        bus.attack_busy = 1'b0; step();
        check_eq("a1_recovery", 32'(state), 32'd2);
        steps(3);
        check_eq("a1_rec_3", 32'(state), 32'd2);
        step();
        check_eq("a1_idle", 32'(state), 32'd0);

        // Buffered atk2 press during ATTACK fires on the first IDLE frame
        btn_atk1 = 1'b1; step();
        btn_atk1 = 1'b0; bus.attack_busy = 1'b1; steps(2);
        btn_atk2 = 1'b1; step();
        btn_atk2 = 1'b0; bus.attack_busy = 1'b0; step();
        check_eq("buf_rec", 32'(state), 32'd2);
        steps(4);
        check_eq("buf_idle", 32'(state), 32'd0);
        check_eq("buf_no_early", 32'(bus.atk2_start), 32'd0);
        step();
        check_eq("buf_atk2_start", 32'(bus.atk2_start), 32'd1);
        check_eq("buf_atk2_state", 32'(state), 32'd1);
        bus.attack_busy = 1'b1; step();
        bus.attack_busy = 1'b0; step(); steps(4);
        check_eq("buf_done_idle", 32'(state), 32'd0);

        // Buffered press 7 frames before IDLE expires
        btn_atk1 = 1'b1; step();
        btn_atk1 = 1'b0; bus.attack_busy = 1'b1; step();
        btn_atk2 = 1'b1; step();
        btn_atk2 = 1'b0; step();
        bus.attack_busy = 1'b0; step();
        steps(4);
        check_eq("exp_idle", 32'(state), 32'd0);
        step();
        check_eq("exp_no_start", 32'({bus.atk1_start, bus.atk2_start}), 32'd0);
        check_eq("exp_stay_idle", 32'(state), 32'd0);

        // Simultaneous press: attack 1 wins; held buttons give one start only
        starts = 0;
        btn_atk1 = 1'b1; btn_atk2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.attack_busy = (i >= 1 && i <= 2);
            step();
            if (i == 0) begin
                check_eq("sim_atk1", 32'(bus.atk1_start), 32'd1);
                check_eq("sim_atk2", 32'(bus.atk2_start), 32'd0);
            end
            starts += int'(bus.atk1_start) + int'(bus.atk2_start);
        end
        check_eq("held_one_start", 32'(starts), 32'd1);
        btn_atk1 = 1'b0; btn_atk2 = 1'b0; bus.attack_busy = 1'b0; step();

        // Attack unit never goes busy: forced exit after ATK_TIMEOUT frames
        btn_atk1 = 1'b1; step();
        btn_atk1 = 1'b0; steps(39);
        check_eq("tmo_still_atk", 32'(state), 32'd1);
        step();
        check_eq("tmo_recovery", 32'(state), 32'd2);
        steps(4);
        check_eq("tmo_idle", 32'(state), 32'd0);

        // Hit during ATTACK: cancel, damage, 12 frames of hitstun, press discarded
        btn_atk1 = 1'b1; step();
        btn_atk1 = 1'b0; bus.attack_busy = 1'b1;
        hit_taken = 1'b1; damage_in = 4'd9; step();
        hit_taken = 1'b0; bus.attack_busy = 1'b0;
        check_eq("hit_health", 32'(health), 32'd91);
        check_eq("hit_cancel", 32'(bus.atk_cancel), 32'd1);
        check_eq("hit_hurt", 32'(hurt), 32'd1);
        check_eq("hit_state", 32'(state), 32'd3);
        for (int i = 1; i <= 11; i++) begin
            btn_atk2 = (i == 2);
            step();
            if (i == 1) check_eq("hit_cancel_1frame", 32'(bus.atk_cancel), 32'd0);
        end
        btn_atk2 = 1'b0;
        check_eq("hs_still_hurt", 32'({hurt, state}), 32'({1'b1, 3'd3}));
        step();
        check_eq("hs_end", 32'({hurt, state}), 32'({1'b0, 3'd0}));
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            starts += int'(bus.atk1_start) + int'(bus.atk2_start);
        end
        check_eq("hs_press_dropped", 32'(starts), 32'd0);

        // Drain health to 5, then a 9-damage hit saturates at 0 and KOs
        hit_taken = 1'b1; damage_in = 4'd15; steps(5);
        damage_in = 4'd11; step();
        check_eq("drain_health", 32'(health), 32'd5);
        check_eq("drain_hitstun", 32'(state), 32'd3);
        damage_in = 4'd9; step();
        check_eq("ko_health", 32'(health), 32'd0);
        check_eq("ko_flag", 32'({ko, hurt}), 32'({1'b1, 1'b0}));
        check_eq("ko_state", 32'(state), 32'd4);
        damage_in = 4'd3; btn_atk1 = 1'b1; step();
        check_eq("ko_ignores", 32'({health, state, bus.atk1_start}), 32'({7'd0, 3'd4, 1'b0}));
        hit_taken = 1'b0; btn_atk1 = 1'b0;
        round_restart = 1'b1; step();
        round_restart = 1'b0;
        check_eq("restart_health", 32'(health), 32'd100);
        check_eq("restart_state", 32'({ko, state}), 32'd0);

        // Zero-damage hit still causes hitstun
        hit_taken = 1'b1; damage_in = 4'd0; step();
        hit_taken = 1'b0;
        check_eq("zero_dmg", 32'({health, hurt, state}), 32'({7'd100, 1'b1, 3'd3}));
        steps(12);
        check_eq("zero_dmg_idle", 32'(state), 32'd0);

        // Async reset in ATTACK with the start pulse high
        hit_taken = 1'b1; damage_in = 4'd7; step();
        hit_taken = 1'b0; steps(12);
        check_eq("pre_rst_health", 32'(health), 32'd93);
        btn_atk1 = 1'b1; step();
        btn_atk1 = 1'b0;
        check_eq("pre_rst_start", 32'(bus.atk1_start), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("arst_outs", 32'({bus.atk1_start, bus.atk2_start, bus.atk_cancel, hurt, ko}), 32'd0);
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_health", 32'(health), 32'd100);
        @(negedge clk) reset = 1'b0;

        // No changes while SCEN stays low
        btn_atk1 = 1'b1; hit_taken = 1'b1; damage_in = 4'd5;
        repeat (20) @(negedge clk);
        check_eq("noscen", 32'({health, state, bus.atk1_start, hurt}), 32'({7'd100, 3'd0, 1'b0, 1'b0}));
        btn_atk1 = 1'b0; hit_taken = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/player_action_ctrl.md
Name: player_action_ctrl

Overview:
Per-player action scheduler that sits in front of the attack unit. It turns raw attack buttons into one-frame start commands, buffers one early press, and enforces post-attack recovery. It also arbitrates incoming hits against the player's own actions: it applies damage, enforces hitstun, cancels attacks and latches KO. All sequencing runs on the frame strobe SCEN; its outputs drive the attack unit, the sprite mapper and the HUD.

Parameters:
RECOVERY_FRAMES, 4, SCEN frames locked out after an attack ends (1..15)
HITSTUN_FRAMES, 12, SCEN frames of hitstun per hit (1..63)
BUFFER_FRAMES, 6, lifetime of a buffered press in SCEN frames (1..15)
ATK_TIMEOUT, 40, max SCEN frames in ATTACK before forced exit (1..63)
MAX_HEALTH, 100, health value after reset or round restart (1..127)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
SCEN  in  1  one-clk frame strobe; all state updates occur only on clk edges with SCEN=1
btn_atk1  in  1  raw level, attack 1 button (synchronised upstream)
btn_atk2  in  1  raw level, attack 2 button
attack_busy  in  1  high while the attack unit is not idle
hit_taken  in  1  level from hit detection, sampled on SCEN
damage_in  in  4  damage for this hit, sampled with hit_taken
round_restart  in  1  level, sampled on SCEN: restore health and go IDLE
atk1_start  out  1  registered command to the attack unit, high for exactly one SCEN period
atk2_start  out  1  as atk1_start, for attack 2
atk_cancel  out  1  one-SCEN-period pulse: the current attack was interrupted by a hit
hurt  out  1  high while in HITSTUN
ko  out  1  high in KO
health  out  7  current health
state  out  3  IDLE=0, ATTACK=1, RECOVERY=2, HITSTUN=3, KO=4

Behaviour:
- Reset: state=IDLE, health=MAX_HEALTH. All pulse outputs, hurt, ko, counters, button history and the buffer are cleared. Reset mid-operation aborts immediately; no pulse may survive it.
- Edge detect: on each SCEN, press1 = btn_atk1 & ~prev1 (same for press2), then prev updates. A held button gives one press only.
- Simultaneous press1 and press2 in the same frame: attack 1 wins; press2 is discarded.
- Pulse outputs are re-evaluated every SCEN and default to 0. Each is high for exactly one SCEN period, from the SCEN edge that sets it to the next SCEN edge.
- Buffer: one entry {valid, id, age}. A press when no start is possible (ATTACK or RECOVERY) loads the buffer with age=0; a newer press overwrites it. Age increments each SCEN; the entry is invalidated when age reaches BUFFER_FRAMES. The buffer is cleared on entry to HITSTUN, KO or a round restart.
- IDLE: a fresh press (fresh has priority), else a valid buffer entry, sets the matching start pulse. On the same edge: state→ATTACK, guard=0, seen=0, buffer cleared. Latency is one SCEN edge from the sampled press to start=1.
- ATTACK: guard increments each SCEN; seen is set once attack_busy=1 is sampled. Exit to RECOVERY (rc=0) when seen=1 and attack_busy=0, or when guard reaches ATK_TIMEOUT.
- RECOVERY: rc increments each SCEN; after RECOVERY_FRAMES frames, state→IDLE. A valid buffer entry is consumed on the following IDLE frame.
- Hit (hit_taken=1 on SCEN) in any state except KO, highest priority after round_restart:
  - health ← max(health − damage_in, 0), saturating, with no wrap.
  - damage_in=0 is still a hit and still causes hitstun.
  - New health 0 → KO. Otherwise → HITSTUN with hs=0.
  - From ATTACK, also pulse atk_cancel and suppress any start pulse that frame.
  - A hit in HITSTUN restarts hs.
- HITSTUN: hurt=1; state→IDLE after HITSTUN_FRAMES frames. Presses during hitstun are discarded, not buffered.
- KO: ko=1. Hits and presses are ignored; only reset or round_restart leaves KO.
- round_restart=1 on SCEN overrides everything: health=MAX_HEALTH, state→IDLE, buffer and counters cleared, no pulses that frame.
- No state or output changes on clk edges where SCEN=0.

Decomposition:
- Shared package / include file: the state encodings and a HEALTH_W=7 constant, reused by the sprite mapper and the HUD.
- One natural sub-module, input_buffer_1: edge detect, priority selection and the aging buffer entry. It outputs press_valid/press_id and accepts a consume/clear input.
- The FSM, counters and health arithmetic stay in the top module.

Test Plan:
- IDLE, press btn_atk1 on SCEN frame N → atk1_start=1 for frame N+1 only. attack_busy high for 7 frames then low → state ATTACK→RECOVERY, then IDLE after 4 frames.
- Press atk2 during ATTACK frame 3, then nothing → on the first IDLE frame atk2_start fires. Repeat with the press 7 frames before IDLE → buffer expires and no start occurs.
- btn_atk1 and btn_atk2 rise in the same frame → only atk1_start. Button held for 20 frames → exactly one start.
- ATTACK with health=100, hit_taken with damage 9 → health=91, atk_cancel one frame, hurt for 12 frames, then IDLE. A press during hitstun produces no later start.
- health=5, hit with damage 9 → health=0 and ko=1; a further hit or press causes no change. round_restart → health=100, IDLE.
- Assert reset during ATTACK with atk1_start high → all outputs cleared asynchronously, health=100. With SCEN held low, button and hit activity changes nothing.
